// File: rtl/drum_trigger_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | drum_trigger_arbiter: round-robin share of one sample voice among pads,   |
// | with pending latches, watchdog and optional retrigger (DRUM_ARB_RETRIGGER_EN)|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module drum_trigger_arbiter #(
  parameter int N_PADS  = 4,
  parameter int TIMEOUT = 65535,
  localparam int ID_W   = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [N_PADS-1:0] pad_evt_i,
  input  logic              player_done_i,
  output logic              play_start_o,
  output logic [ID_W-1:0]   play_id_o,
  output logic              play_abort_o,
  output logic              busy_o,
  output logic              timeout_err_o,
  output logic [7:0]        drop_cnt_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_END  = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
`ifdef DRUM_ARB_RETRIGGER_EN
    S_RESTART = 2'd2,
`endif
    S_PLAY    = 2'd1
  } state_t;

  state_t            state_q, state_d;
  logic [N_PADS-1:0] pending_q, pending_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic [ID_W-1:0]   play_id_q, play_id_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              play_start_q, play_start_d;
  logic              timeout_err_q, timeout_err_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic [N_PADS-1:0] pending_clr;
  logic [N_PADS-1:0] retrig;
  logic [N_PADS-1:0] drops;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [31:0]       cand_w;
  logic [ID_W-1:0]   cand;
  logic [8:0]        drop_sum;

`ifdef DRUM_ARB_RETRIGGER_EN
  logic play_abort_q, play_abort_d;
`endif

  // Round-robin search starting just after the last granted pad.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_w      = '0;
    cand        = '0;
    for (int k = 1; k <= N_PADS; k++) begin
      cand_w = (32'(last_id_q) + 32'(k)) % 32'(N_PADS);
      cand   = cand_w[ID_W-1:0];
      if (!grant_found && pending_q[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_id_d     = last_id_q;
    play_id_d     = play_id_q;
    wd_d          = wd_q;
    play_start_d  = 1'b0;
    timeout_err_d = 1'b0;
    pending_clr   = '0;
    retrig        = '0;
`ifdef DRUM_ARB_RETRIGGER_EN
    play_abort_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          play_start_d           = 1'b1;
          play_id_d              = grant_idx;
          last_id_d              = grant_idx;
          pending_clr[grant_idx] = 1'b1;
          wd_d                   = '0;
          state_d                = S_PLAY;
        end
      end
      S_PLAY: begin
`ifdef DRUM_ARB_RETRIGGER_EN
        if (pad_evt_i[play_id_q] && (wd_q != WD_END)) begin
          retrig[play_id_q] = 1'b1;
          play_abort_d      = 1'b1;
          state_d           = S_RESTART;
        end else
`endif
        // WD_END is a one-cycle tail after expiry so IDLE starts a cycle after the error pulse.
        if (player_done_i || (wd_q == WD_END)) begin
          state_d = S_IDLE;
        end else begin
          if (wd_q == WD_LAST) timeout_err_d = 1'b1;
          wd_d = wd_q + 1'b1;
        end
      end
`ifdef DRUM_ARB_RETRIGGER_EN
      S_RESTART: begin
        play_start_d = 1'b1;
        wd_d         = '0;
        state_d      = S_PLAY;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // A trigger coinciding with its own grant survives; only a truly redundant one is dropped.
  always_comb begin
    pending_d = (pending_q & ~pending_clr) | (pad_evt_i & ~retrig);
    drops     = pad_evt_i & pending_q & ~pending_clr & ~retrig;
    drop_sum  = {1'b0, drop_cnt_q};
    for (int i = 0; i < N_PADS; i++) begin
      drop_sum = drop_sum + {8'd0, drops[i]};
    end
    drop_cnt_d = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      last_id_q     <= ID_W'(N_PADS - 1);
      play_id_q     <= '0;
      wd_q          <= '0;
      play_start_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      last_id_q     <= last_id_d;
      play_id_q     <= play_id_d;
      wd_q          <= wd_d;
      play_start_q  <= play_start_d;
      timeout_err_q <= timeout_err_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

`ifdef DRUM_ARB_RETRIGGER_EN
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) play_abort_q <= 1'b0;
    else         play_abort_q <= play_abort_d;
  end
  assign play_abort_o = play_abort_q;
`else
  assign play_abort_o = 1'b0;
`endif

  assign play_start_o  = play_start_q;
  assign play_id_o     = play_id_q;
  assign busy_o        = (state_q != S_IDLE);
  assign timeout_err_o = timeout_err_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_drum_trigger_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_drum_trigger_arbiter: directed bench with grant scoreboard            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_drum_trigger_arbiter;

  localparam int N_PADS  = 4;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] pad_evt;
  logic       player_done;
  logic       play_start;
  logic [1:0] play_id;
  logic       play_abort;
  logic       busy;
  logic       timeout_err;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  bit sb_en = 1'b1;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  drum_trigger_arbiter #(.N_PADS(N_PADS), .TIMEOUT(TIMEOUT)) dut (
    .clk_i         (clk),
    .nrst_i        (nrst),
    .pad_evt_i     (pad_evt),
    .player_done_i (player_done),
    .play_start_o  (play_start),
    .play_id_o     (play_id),
    .play_abort_o  (play_abort),
    .busy_o        (busy),
    .timeout_err_o (timeout_err),
    .drop_cnt_o    (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!play_start && n < 40);
    chk(tag, play_start, 1);
  endtask

  task automatic done_pulse();
    player_done = 1'b1;
    step();
    player_done = 1'b0;
  endtask

  task automatic reset_dut();
    pad_evt     = '0;
    player_done = 1'b0;
    nrst        = 1'b0;
    step();
    nrst = 1'b1;
    step();
    exp_q.delete();
  endtask

  task automatic pulse(input logic [3:0] v);
    pad_evt = v;
    step();
    pad_evt = '0;
  endtask

  // Every play_start must match the oldest expected grant.
  always @(negedge clk) begin
    int unsigned e;
    if (nrst && sb_en && play_start) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_start", play_start, 0);
      end else begin
        e = exp_q.pop_front();
        chk("grant_id", play_id, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    nrst        = 1'b0;
    pad_evt     = '0;
    player_done = 1'b0;
    step();
    step();
    chk("rst_start", play_start, 0);
    chk("rst_id", play_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", play_abort, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_drop", drop_cnt, 0);
    nrst = 1'b1;
    step();

    // Basic latency: evt at t, start at t+2, done at u, idle at u+1.
    exp_q.push_back(0);
    pulse(4'b0001);
    chk("lat1_start", play_start, 0);
    chk("lat1_busy", busy, 0);
    step();
    chk("lat2_start", play_start, 1);
    chk("lat2_busy", busy, 1);
    chk("lat2_id", play_id, 0);
    step();
    step();
    done_pulse();
    chk("done_busy", busy, 0);
    chk("done_start", play_start, 0);

    // All pads at once: grants 0..3 in order.
    reset_dut();
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    pulse(4'b1111);
    for (int i = 0; i < 4; i++) begin
      wait_start($sformatf("rr_start%0d", i));
      step();
      step();
      chk("rr_hold", play_id, i);
      done_pulse();
      chk("rr_idle", busy, 0);
      chk("rr_hold_idle", play_id, i);
    end

    // Duplicate triggers during a play are dropped.
    reset_dut();
    exp_q.push_back(0);
    pulse(4'b0001);
    wait_start("drop_s0");
    exp_q.push_back(2);
    pulse(4'b0100);
    step();
    pulse(4'b0100);
    step();
    pulse(4'b0100);
    chk("drop_two", drop_cnt, 2);
    done_pulse();
    wait_start("drop_s2");
    done_pulse();
    chk("drop_keep", drop_cnt, 2);

    sb_en   = 1'b0;
    pad_evt = 4'b1111;
    repeat (120) step();
    pad_evt = '0;
    chk("drop_sat", drop_cnt, 255);
    reset_dut();
    sb_en = 1'b1;
    chk("drop_rst", drop_cnt, 0);

    // Watchdog: error exactly TIMEOUT cycles after start, next grant two later.
    exp_q.push_back(1);
    exp_q.push_back(3);
    pulse(4'b1010);
    wait_start("to_s1");
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      chk("to_early", timeout_err, 0);
    end
    step();
    chk("to_err", timeout_err, 1);
    chk("to_busy_tail", busy, 1);
    step();
    chk("to_err_off", timeout_err, 0);
    chk("to_idle", busy, 0);
    chk("to_gap", play_start, 0);
    step();
    chk("to_next", play_start, 1);
    chk("to_next_id", play_id, 3);
    done_pulse();

    // Done on the expiry cycle wins.
    exp_q.push_back(0);
    pulse(4'b0001);
    wait_start("dw_s0");
    repeat (TIMEOUT - 1) step();
    done_pulse();
    chk("dw_err", timeout_err, 0);
    chk("dw_idle", busy, 0);

    // Pad 1 re-triggered during its own play.
    reset_dut();
    exp_q.push_back(1);
    pulse(4'b0010);
    wait_start("rt_s1");
    step();
    step();
    exp_q.push_back(1);
    pulse(4'b0010);
`ifdef DRUM_ARB_RETRIGGER_EN
    chk("rt_abort", play_abort, 1);
    chk("rt_busy", busy, 1);
    chk("rt_nostart", play_start, 0);
    step();
    chk("rt_start", play_start, 1);
    chk("rt_abort_off", play_abort, 0);
    chk("rt_drop", drop_cnt, 0);
    done_pulse();
`else
    chk("rt_abort", play_abort, 0);
    chk("rt_busy", busy, 1);
    done_pulse();
    wait_start("rt_again");
    chk("rt_drop", drop_cnt, 0);
    done_pulse();
`endif

    // Async reset mid-play discards pending requests.
    reset_dut();
    exp_q.push_back(3);
    pulse(4'b1000);
    wait_start("mr_s3");
    pulse(4'b0110);
    step();
    exp_q.delete();
    nrst = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_start", play_start, 0);
    chk("mr_id", play_id, 0);
    step();
    nrst = 1'b1;
    repeat (8) step();
    chk("mr_quiet", busy, 0);
    exp_q.push_back(0);
    pulse(4'b0001);
    wait_start("mr_new");
    done_pulse();
    step();

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/drum_trigger_arbiter.md
# drum_trigger_arbiter

Shares the single sample-playback voice between several drum pads. Each pad delivers one-cycle trigger pulses from its synchronised edge detector; the block latches them as pending requests and grants the voice round-robin. It issues a start pulse with the pad index and waits for the voice to report completion, with a watchdog timeout. It sits between the per-pad button debouncers and the sample player.

## Interface
- N_PADS, 4, number of pad requesters (2..16)
- TIMEOUT, 65535, max cycles in PLAY before forced release (≥2)
- ID_W, $clog2(N_PADS), width of play_id (derived, not overridden)

- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- pad_evt  in  N_PADS  one-cycle trigger pulse per pad, already synchronised to clk
- player_done  in  1  one-cycle pulse: voice finished current sample
- play_start  out  1  one-cycle pulse: voice must start sample play_id
- play_id  out  ID_W  pad index being played; held stable until next grant
- play_abort  out  1  one-cycle pulse: voice must stop immediately (retrigger only)
- busy  out  1  high while state is PLAY or RESTART
- timeout_err  out  1  one-cycle pulse on watchdog expiry
- drop_cnt  out  8  saturating count of discarded triggers

## Operation
- pending[N_PADS-1:0] register; pad_evt[i]=1 sets pending[i] next cycle.
- pad_evt[i] while pending[i] already 1: event dropped, drop_cnt += 1, saturating at 255; simultaneous drops on k pads add k (saturating).
- pad_evt[i] in the same cycle pending[i] is cleared by a grant: event wins, pending[i] stays 1, no drop.
- Round-robin: search starts at last_id+1 mod N_PADS, first pending bit wins; last_id resets to N_PADS-1 so pad 0 wins first.
- States: IDLE, PLAY, RESTART.
  - IDLE: pending≠0 → play_start=1, play_id=winner, clear pending[winner], last_id=winner, go PLAY, watchdog=0.
  - PLAY: player_done → IDLE. Else watchdog=TIMEOUT-1 → timeout_err=1, IDLE. Else watchdog+1.
  - RESTART (macro only): play_start=1, same play_id, watchdog=0, go PLAY.
- player_done outside PLAY ignored.
- Reset (any time, mid-play included): state IDLE, pending=0, last_id=N_PADS-1, watchdog=0, drop_cnt=0, all outputs 0, play_id=0. The voice is not told of reset; the top level resets it too.

## Timing
- pad_evt at cycle t → pending at t+1 → play_start at t+2 when IDLE (trigger latency 2 cycles).
- player_done at cycle u → IDLE at u+1 → next play_start earliest u+2 (min gap 1 idle cycle).
- Timeout: play_start at s, no done → timeout_err at s+TIMEOUT, IDLE from s+TIMEOUT+1.
- player_done in the same cycle as watchdog expiry: done wins, no timeout_err.
- All outputs registered; no combinational input-to-output path.

## Configuration
- DRUM_ARB_RETRIGGER_EN defined: in PLAY, pad_evt[play_id] → play_abort=1 next cycle, state RESTART, pending[play_id] not set, no drop counted. The following cycle gives play_start with the same id. player_done arriving in that same cycle is ignored.
- Undefined: no RESTART state, play_abort tied 0; pad_evt[play_id] during PLAY is handled as a normal pending request.

## Test plan
- Reset, pad_evt=4'b0001 at t=10 → play_start=1, play_id=0 at t=12; busy=1 from t=12; player_done at t=20 → busy=0 at t=21.
- pad_evt=4'b1111 single pulse from IDLE → grants in order 0,1,2,3, each after the prior player_done, with play_id held between grants.
- Pad 2 pulsed three times during one PLAY of pad 0, macro off → one later grant for pad 2, drop_cnt=2; 300 drops → drop_cnt=255.
- TIMEOUT=8, no player_done → timeout_err pulse exactly 8 cycles after play_start; next pending pad granted 2 cycles later.
- DRUM_ARB_RETRIGGER_EN, pad 1 re-pulsed during its own PLAY at t → play_abort at t+1, play_start with play_id=1 at t+2, drop_cnt unchanged.
- nrst low for 1 cycle during PLAY with pending=4'b0110 → all outputs 0, pending cleared, no play_start until a new pad_evt.
